// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div over a fixed
// busy window and serves mfhi/mflo reads combinationally.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI_Out,
  output logic [31:0] LO_Out,
  output logic [31:0] MD_Out
);

  // state   | meaning
  // ST_IDLE | no operation in flight; mult/div may start, mthi/mtlo accepted
  // ST_BUSY | result held in temp_hi/temp_lo, counting down to write-back
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   hi_q, lo_q, temp_hi, temp_lo;
  logic          temp_wr;

  logic       is_special;
  logic [5:0] funct;
  logic       op_mult, op_multu, op_div, op_divu, op_mfhi, op_mthi, op_mflo, op_mtlo;
  logic       op_md, op_any_div;
  logic       unused_ir_bits;

  assign is_special     = (IR_E[31:26] == 6'h00);
  assign funct          = IR_E[5:0];
  assign op_mult        = is_special && (funct == 6'h18);
  assign op_multu       = is_special && (funct == 6'h19);
  assign op_div         = is_special && (funct == 6'h1A);
  assign op_divu        = is_special && (funct == 6'h1B);
  assign op_mfhi        = is_special && (funct == 6'h10);
  assign op_mthi        = is_special && (funct == 6'h11);
  assign op_mflo        = is_special && (funct == 6'h12);
  assign op_mtlo        = is_special && (funct == 6'h13);
  assign op_md          = op_mult | op_multu | op_div | op_divu;
  assign op_any_div     = op_div | op_divu;
  assign unused_ir_bits = ^IR_E[25:6];

  logic [63:0] sext_rs, sext_rt, prod_s, prod_u;
  assign sext_rs = {{32{RS_E[31]}}, RS_E};
  assign sext_rt = {{32{RT_E[31]}}, RT_E};
  assign prod_s  = sext_rs * sext_rt;
  assign prod_u  = {32'h0, RS_E} * {32'h0, RT_E};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  logic [31:0] den_safe, mag_rs, mag_rt, q_mag, r_mag, q_s, r_s, q_u, r_u;
  assign den_safe = (RT_E == 32'h0) ? 32'h1 : RT_E;
  assign mag_rs   = RS_E[31] ? -RS_E : RS_E;
  assign mag_rt   = den_safe[31] ? -den_safe : den_safe;
  assign q_mag    = mag_rs / mag_rt;
  assign r_mag    = mag_rs % mag_rt;
  assign q_s      = (RS_E[31] ^ RT_E[31]) ? -q_mag : q_mag;
  assign r_s      = RS_E[31] ? -r_mag : r_mag;
  assign q_u      = RS_E / den_safe;
  assign r_u      = RS_E % den_safe;

  logic [31:0] res_hi, res_lo;
  always_comb begin
    res_hi = 32'h0;
    res_lo = 32'h0;
    if (op_mult) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (op_multu) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else if (op_div) begin
      res_hi = r_s;
      res_lo = q_s;
    end else if (op_divu) begin
      res_hi = r_u;
      res_lo = q_u;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (op_md) state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == CW'(1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign Busy  = (state == ST_BUSY);
  assign Start = op_md && !Busy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      temp_hi <= 32'h0;
      temp_lo <= 32'h0;
      temp_wr <= 1'b0;
      cnt     <= '0;
    end else if (Start) begin
      temp_hi <= res_hi;
      temp_lo <= res_lo;
      temp_wr <= !(op_any_div && (RT_E == 32'h0));
      cnt     <= op_any_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (Busy) begin
      if (cnt == CW'(1)) begin
        if (temp_wr) begin
          hi_q <= temp_hi;
          lo_q <= temp_lo;
        end
        cnt <= '0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end else if (op_mthi) begin
      hi_q <= RS_E;
    end else if (op_mtlo) begin
      lo_q <= RS_E;
    end
  end

  assign HI_Out = hi_q;
  assign LO_Out = lo_q;

  always_comb begin
    MD_Out = 32'h0;
    if (op_mfhi)      MD_Out = hi_q;
    else if (op_mflo) MD_Out = lo_q;
  end

endmodule
